// File: rtl/pudiannao_pkg.sv
// Shared constants and types for the lane reduction/accumulation datapath.
// Default widths match the 16-lane adder array feeding this block.
package pudiannao_pkg;

   localparam int LANES     = 16;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_ACC_W = 32;
   localparam int DEF_CNT_W = 16;

   typedef logic signed [DEF_WIDTH-1:0] lane_t;
   typedef logic signed [DEF_ACC_W-1:0] acc_t;

endpackage

// File: rtl/lane_reduce_acc_if.sv
// Beat input stream and result output stream of lane_reduce_acc.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface lane_reduce_acc_if import pudiannao_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
) ();

   logic [WIDTH-1:0] in_data [LANES-1:0];
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_beats;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_sum, out_beats, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_sum, out_beats, out_valid
   );

endinterface

// File: rtl/reduce_pair_stage.sv
// One registered level of the reduction tree: N operands -> N/2 pairwise sums,
// with valid and last carried alongside; holds everything while en is low.
module reduce_pair_stage #(
   parameter int N = 16,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         in_valid,
   input  logic         in_last,
   input  logic [W-1:0] in_data [N-1:0],
   output logic         out_valid,
   output logic         out_last,
   output logic [W-1:0] out_data [N/2-1:0]
);

   // NOTE: state is updated with <= so every stage samples its predecessor's old
   // value on the same edge; blocking assignments here would collapse the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         // NOTE: the sum registers are reset along with the valid bit so that a
         // bubble never carries X into the next level or the accumulator.
         for (int i = 0; i < N/2; i++) out_data[i] <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_last  <= in_last;
         for (int i = 0; i < N/2; i++) out_data[i] <= in_data[2*i] + in_data[2*i+1];
      end
   end

endmodule

// File: rtl/lane_reduce_acc.sv
// Reduces 16 lane sums per beat through a 4-level adder tree, accumulates the
// scalars over a burst closed by in_last, and presents one result per burst.
module lane_reduce_acc import pudiannao_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic               clk,
   input logic               rst,
   lane_reduce_acc_if.slave  bus
);

   logic             en;
   logic [ACC_W-1:0] lane_ext [LANES-1:0];
   logic [ACC_W-1:0] s1_data [7:0];
   logic [ACC_W-1:0] s2_data [3:0];
   logic [ACC_W-1:0] s3_data [1:0];
   logic [ACC_W-1:0] s4_data [0:0];
   logic             s1_valid, s2_valid, s3_valid, s4_valid;
   logic             s1_last,  s2_last,  s3_last,  s4_last;

   logic [ACC_W-1:0] acc_q, sum_next, out_sum_q;
   logic [CNT_W-1:0] cnt_q, cnt_next, out_beats_q;
   logic             first_q, out_valid_q;

   // A held result freezes the whole pipeline, input acceptance included.
   assign en            = !(out_valid_q && !bus.out_ready);
   assign bus.in_ready  = en;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_beats = out_beats_q;
   assign bus.out_valid = out_valid_q;

   always_comb begin
      for (int i = 0; i < LANES; i++)
         lane_ext[i] = {{(ACC_W-WIDTH){bus.in_data[i][WIDTH-1]}}, bus.in_data[i]};
   end

   reduce_pair_stage #(.N(16), .W(ACC_W)) u_s1 (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(bus.in_valid), .in_last(bus.in_last), .in_data(lane_ext),
      .out_valid(s1_valid), .out_last(s1_last), .out_data(s1_data)
   );

   reduce_pair_stage #(.N(8), .W(ACC_W)) u_s2 (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(s1_valid), .in_last(s1_last), .in_data(s1_data),
      .out_valid(s2_valid), .out_last(s2_last), .out_data(s2_data)
   );

   reduce_pair_stage #(.N(4), .W(ACC_W)) u_s3 (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(s2_valid), .in_last(s2_last), .in_data(s2_data),
      .out_valid(s3_valid), .out_last(s3_last), .out_data(s3_data)
   );

   reduce_pair_stage #(.N(2), .W(ACC_W)) u_s4 (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(s3_valid), .in_last(s3_last), .in_data(s3_data),
      .out_valid(s4_valid), .out_last(s4_last), .out_data(s4_data)
   );

   // NOTE: both outputs are assigned on every path through this block, so no
   // latch is inferred.
   always_comb begin
      sum_next = (first_q ? '0 : acc_q) + s4_data[0];
      if (first_q)     cnt_next = CNT_W'(1);
      else if (&cnt_q) cnt_next = cnt_q;
      else             cnt_next = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b1;
         out_sum_q   <= '0;
         out_beats_q <= '0;
         out_valid_q <= 1'b0;
      end else if (en) begin
         if (s4_valid && s4_last) begin
            out_sum_q   <= sum_next;
            out_beats_q <= cnt_next;
            out_valid_q <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
         end else begin
            // en is only high with a pending result when out_ready pops it.
            if (out_valid_q) out_valid_q <= 1'b0;
            if (s4_valid) begin
               acc_q   <= sum_next;
               cnt_q   <= cnt_next;
               first_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_lane_reduce_acc.sv
// Directed bench for lane_reduce_acc: latency, burst sums, sign handling,
// output back-pressure, gapped input and mid-burst reset.
module tb_lane_reduce_acc;
   import pudiannao_pkg::*;

   localparam int WIDTH = 16;
   localparam int ACC_W = 32;
   localparam int CNT_W = 16;

   typedef struct {
      logic [ACC_W-1:0] sum;
      logic [CNT_W-1:0] beats;
   } result_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   result_t got_q[$];

   lane_reduce_acc_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   lane_reduce_acc #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so the negedge sees a stable handshake.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
         got_q.push_back('{sum: bus.out_sum, beats: bus.out_beats});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   function automatic result_t pop_result();
      result_t r;
      r.sum   = 'x;
      r.beats = 'x;
      if (got_q.size() > 0) r = got_q.pop_front();
      return r;
   endfunction

   task automatic wait_results(input int n, input int budget);
      int c = 0;
      while (got_q.size() < n && c < budget) begin
         tick();
         c++;
      end
   endtask

   // Lane i carries base + i*step; the beat is held until in_ready accepts it.
   task automatic send_beat(input logic [WIDTH-1:0] base, input logic [WIDTH-1:0] step,
                            input logic last);
      int waited = 0;
      for (int i = 0; i < LANES; i++) bus.in_data[i] = base + WIDTH'(i) * step;
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_beat: in_ready=%b after %0d cycles, required 1", bus.in_ready, waited);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic test_reset();
      ticks(2);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
      end
      n_checks++;
      if (bus.out_sum !== '0) begin
         n_fail++; $display("FAIL reset_out_sum: got %h, required 0", bus.out_sum);
      end
      n_checks++;
      if (bus.out_beats !== '0) begin
         n_fail++; $display("FAIL reset_out_beats: got %h, required 0", bus.out_beats);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
      end
      rst = 1'b0;
      ticks(2);
   endtask

   task automatic test_single_beat();
      int lat;
      got_q.delete();
      bus.out_ready = 1'b1;
      send_beat(16'd1, 16'd1, 1'b1);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== 5) begin
         n_fail++; $display("FAIL single_latency: got %0d cycles, required 5", lat);
      end
      n_checks++;
      if (bus.out_sum !== 32'd136) begin
         n_fail++; $display("FAIL single_sum: got %0d, required 136", bus.out_sum);
      end
      n_checks++;
      if (bus.out_beats !== 16'd1) begin
         n_fail++; $display("FAIL single_beats: got %0d, required 1", bus.out_beats);
      end
      ticks(4);
      n_checks++;
      if (got_q.size() !== 1) begin
         n_fail++; $display("FAIL single_count: got %0d results, required 1", got_q.size());
      end
   endtask

   task automatic test_burst_max();
      result_t r;
      got_q.delete();
      send_beat(16'h7FFF, 16'd0, 1'b0);
      send_beat(16'h7FFF, 16'd0, 1'b0);
      ticks(8);
      n_checks++;
      if (got_q.size() !== 0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_early: got %0d results out_valid=%b, required 0 and 0",
                  got_q.size(), bus.out_valid);
      end
      send_beat(16'h7FFF, 16'd0, 1'b1);
      wait_results(1, 20);
      r = pop_result();
      n_checks++;
      if (r.sum !== 32'h0017_FFD0) begin
         n_fail++; $display("FAIL burst_sum: got %h, required 0017ffd0", r.sum);
      end
      n_checks++;
      if (r.beats !== 16'd3) begin
         n_fail++; $display("FAIL burst_beats: got %0d, required 3", r.beats);
      end
   endtask

   task automatic test_negative();
      result_t r;
      got_q.delete();
      send_beat(16'hFFFF, 16'd0, 1'b0);
      send_beat(16'hFFFF, 16'd0, 1'b1);
      wait_results(1, 20);
      r = pop_result();
      n_checks++;
      if (r.sum !== 32'hFFFF_FFE0) begin
         n_fail++; $display("FAIL neg_sum: got %h, required ffffffe0", r.sum);
      end
      n_checks++;
      if (r.beats !== 16'd2) begin
         n_fail++; $display("FAIL neg_beats: got %0d, required 2", r.beats);
      end
   endtask

   task automatic test_back_to_back();
      result_t r;
      int c = 0;
      got_q.delete();
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send_beat(WIDTH'(k), 16'd0, 1'b1);
      while (bus.out_valid !== 1'b1 && c < 20) begin
         tick();
         c++;
      end
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_valid: got %b, required 1", bus.out_valid);
      end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (bus.out_sum !== 32'd16 || bus.out_beats !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_hold[%0d]: got sum=%0d beats=%0d, required 16 and 1",
                     i, bus.out_sum, bus.out_beats);
         end
         n_checks++;
         if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b, required 0", i, bus.in_ready);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      wait_results(4, 30);
      ticks(6);
      n_checks++;
      if (got_q.size() !== 4) begin
         n_fail++; $display("FAIL b2b_count: got %0d results, required 4", got_q.size());
      end
      for (int k = 1; k <= 4; k++) begin
         r = pop_result();
         n_checks++;
         if (r.sum !== ACC_W'(16 * k) || r.beats !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got sum=%0d beats=%0d, required %0d and 1",
                     k, r.sum, r.beats, 16 * k);
         end
      end
   endtask

   task automatic test_gapped();
      result_t r;
      got_q.delete();
      for (int k = 0; k < 4; k++) begin
         send_beat(16'd2, 16'd0, (k == 3));
         ticks(2);
      end
      wait_results(1, 20);
      r = pop_result();
      n_checks++;
      if (r.sum !== 32'd128) begin
         n_fail++; $display("FAIL gap_sum: got %0d, required 128", r.sum);
      end
      n_checks++;
      if (r.beats !== 16'd4) begin
         n_fail++; $display("FAIL gap_beats: got %0d, required 4", r.beats);
      end
   endtask

   task automatic test_reset_mid_burst();
      result_t r;
      got_q.delete();
      send_beat(16'd5, 16'd0, 1'b0);
      send_beat(16'd5, 16'd0, 1'b0);
      rst = 1'b1;
      #2;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_valid[%0d]: got %b, required 0", i, bus.out_valid);
         end
         tick();
      end
      rst = 1'b0;
      tick();
      send_beat(16'd1, 16'd0, 1'b1);
      wait_results(1, 20);
      ticks(6);
      n_checks++;
      if (got_q.size() !== 1) begin
         n_fail++; $display("FAIL rst_mid_count: got %0d results, required 1", got_q.size());
      end
      r = pop_result();
      n_checks++;
      if (r.sum !== 32'd16 || r.beats !== 16'd1) begin
         n_fail++;
         $display("FAIL rst_mid_result: got sum=%0d beats=%0d, required 16 and 1", r.sum, r.beats);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < LANES; i++) bus.in_data[i] = '0;
      test_reset();
      test_single_beat();
      test_burst_max();
      test_negative();
      test_back_to_back();
      test_gapped();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
